uart_tx_drain: RTL and testbench
================================

# uart_tx_drain

Serial transmitter that drains the chip's transmit FIFO and drives an 8N1-style UART line. Sits directly downstream of the show-ahead transmit FIFO: it watches the FIFO's empty flag, pops one word at a time with a single-cycle read enable, and serialises each word LSB-first with start and stop bits at a fixed clocks-per-bit rate. Back-to-back words are sent with no idle gap while the FIFO stays non-empty.

## Interface
- DATA_WIDTH, 8, bits per character; equals the FIFO word width.
- CLKS_PER_BIT, 16, clock cycles per serial bit; must be ≥ 2. The divider counter is $clog2(CLKS_PER_BIT) bits wide.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- tx_en  in  1  allows new characters to be popped; does not abort a frame already in flight.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DATA_WIDTH  FIFO head word, valid combinationally whenever fifo_empty=0.
- fifo_ren  out  1  one-cycle pop strobe to the FIFO; combinational.
- tx  out  1  serial line, registered; idles high.
- busy  out  1  high from the cycle after a pop until the frame ends, when no new pop follows.
- frame_done  out  1  one-cycle pulse in the last clock of each stop bit.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- The pop condition is `tx_en & ~fifo_empty`. It is evaluated in two places only:
  - in IDLE;
  - in the last cycle of STOP.
- When the pop condition is true in one of those cycles:
  - fifo_ren=1 for that single cycle;
  - fifo_rdata is captured into the shift register;
  - the next state is START.
- Otherwise, from STOP the next state is IDLE.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_WIDTH bits, LSB first, each held for CLKS_PER_BIT cycles. A bit index counts 0..DATA_WIDTH-1.
- STOP: tx=1 for CLKS_PER_BIT cycles.
- The divider counts 0..CLKS_PER_BIT-1. It resets to 0 on every state entry. A state or bit advances when the count equals CLKS_PER_BIT-1.
- The block never asserts fifo_ren outside the two pop points. It never asserts fifo_ren while fifo_empty=1.
- tx_en deasserted mid-frame: the current frame completes normally, then the block goes to IDLE.
- fifo_empty rising mid-frame: no effect on the current frame.

## Timing
- Reset values: state=IDLE, tx=1, busy=0, frame_done=0, fifo_ren=0, counters=0, shift register=0.
- rst asserted mid-frame:
  - tx returns high immediately, without waiting for a clock edge;
  - the in-flight character is lost;
  - the popped word is not re-read.
- Latency: the pop occurs in cycle P. tx falls at edge P+1, i.e. tx=0 during cycle P+1, and busy=1 from the same cycle.
- Frame length is (DATA_WIDTH+2)·CLKS_PER_BIT cycles, or +CLKS_PER_BIT with parity.
- Back-to-back: if the pop condition holds in the last STOP cycle, the next start bit begins the following cycle. busy stays 1 and there is zero idle time.
- frame_done and a chained fifo_ren may be high in the same cycle.
- From IDLE, the earliest pop is the first cycle in which the pop condition holds.

## Configuration
- UART_TX_PARITY_EN defined:
  - a PARITY state is inserted between DATA and STOP;
  - it drives the even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles;
  - the frame is (DATA_WIDTH+3)·CLKS_PER_BIT cycles.
- Undefined: no PARITY state and no parity logic; the frame is (DATA_WIDTH+2)·CLKS_PER_BIT cycles.

## Test plan
All scenarios use DATA_WIDTH=8 and CLKS_PER_BIT=4.
- Reset then idle: hold rst, release with fifo_empty=1, tx_en=1 for 50 cycles. Required: tx=1, busy=0, fifo_ren=0 throughout.
- Single byte:
  - stimulus: FIFO holds 0xA5, tx_en=1;
  - fifo_ren pulses exactly once;
  - tx samples at mid-bit: 0, 1,0,1,0,0,1,0,1, then 1;
  - frame_done pulses in cycle 40 after the pop;
  - busy falls afterward.
- Back-to-back:
  - stimulus: FIFO holds 0x00 then 0xFF;
  - the second start bit begins exactly 40 cycles after the first;
  - exactly two fifo_ren pulses, the second coincident with the first frame_done;
  - tx never rises between the first stop bit and the second start bit.
- Gating: clear tx_en 10 cycles into a 0x3C frame with 0x55 queued. Required:
  - 0x3C completes;
  - no further fifo_ren;
  - the block returns to IDLE.
  - Reassert tx_en: 0x55 is sent.
- Reset mid-frame: assert rst 15 cycles into a frame. Required:
  - tx=1 immediately, not at the next edge;
  - busy=0;
  - after release with an empty FIFO, no activity.
- Parity build (UART_TX_PARITY_EN): send 0xA5, then 0x07. Required:
  - parity bit 0 for 0xA5, 1 for 0x07;
  - frame length 44 cycles each.

Source files
------------

// File: rtl/uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_drain
// Brief    : Drains a show-ahead transmit FIFO and serialises each word onto
//            an 8N1-style UART line (start bit, data LSB first, stop bit).
//            Back-to-back words are sent without an idle gap while the FIFO
//            stays non-empty and tx_en stays high.
// Config   : define UART_TX_PARITY_EN to insert an even-parity bit between
//            the last data bit and the stop bit.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            tx_en      - permits new characters to be popped
//            fifo_empty - FIFO empty flag
//            fifo_rdata - FIFO head word (valid while fifo_empty=0)
//            fifo_ren   - one-cycle pop strobe (combinational)
//            tx         - serial line, registered, idles high
//            busy       - a frame is in progress
//            frame_done - pulse in the last clock of each stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_idx_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } t_state;

  t_state                  r_state;
  logic [c_cnt_w-1:0]      r_cnt;
  logic [c_idx_w-1:0]      r_idx;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic                    r_tx;
  logic                    r_busy;
  logic                    r_frame_done;

  t_state                  w_state_next;
  logic [c_cnt_w-1:0]      w_cnt_next;
  logic [c_idx_w-1:0]      w_idx_next;
  logic [DATA_WIDTH-1:0]   w_shift_next;
  logic                    w_tx_next;
  logic                    w_last;
  logic                    w_pop;

`ifdef UART_TX_PARITY_EN
  // Parity is taken from the word as popped, since the shift register has
  // been consumed by the time the parity bit goes out.
  logic r_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity <= 1'b0;
    end else if (fifo_ren) begin
      r_parity <= ^fifo_rdata;
    end
  end
`endif

  // rst is folded in so no pop can escape while reset is held.
  assign w_pop  = tx_en & ~fifo_empty & ~rst;
  assign w_last = (r_cnt == c_cnt_last);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    fifo_ren     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (w_pop) begin
          fifo_ren     = 1'b1;
          w_shift_next = fifo_rdata;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_last) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt_next = '0;
          if (r_idx == c_idx_last) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_shift_next = r_shift >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_last) begin
          w_cnt_next   = '0;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_last) begin
          w_cnt_next = '0;
          // Second pop point: chaining here gives zero idle time.
          if (w_pop) begin
            fifo_ren     = 1'b1;
            w_shift_next = fifo_rdata;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // tx is registered, so its next value is decoded from the next state.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = r_parity;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shift      <= '0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      r_shift      <= w_shift_next;
      r_tx         <= w_tx_next;
      r_busy       <= (w_state_next != S_IDLE);
      r_frame_done <= (w_state_next == S_STOP) && (w_cnt_next == c_cnt_last);
    end
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_drain
// Brief    : Self-checking bench for uart_tx_drain (DATA_WIDTH=8,
//            CLKS_PER_BIT=4). A queue-based FIFO feeds the DUT and a
//            waveform model predicts tx/busy/frame_done/fifo_ren per cycle.
//            Honours UART_TX_PARITY_EN for the expected frame shape.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_drain;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_LEN = (DW + 3) * CPB;
`else
  localparam int FRAME_LEN = (DW + 2) * CPB;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_ren;
  logic          tx;
  logic          busy;
  logic          frame_done;

  always #5 clk = ~clk;

  uart_tx_drain #(
    .DATA_WIDTH   (DW),
    .CLKS_PER_BIT (CPB)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_ren   (fifo_ren),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] fifo_q[$];   // bench-side FIFO contents
  logic          exp_q[$];    // expected tx value for each upcoming cycle
  int            dut_pops;    // fifo_ren pulses seen on the DUT
  int            cyc;
  int            starts[$];   // cycles where the DUT line fell 1->0
  logic          prev_tx;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fifo_q[0];
  endtask

  // Frame as a flat list of per-cycle line levels.
  task automatic push_frame(input logic [DW-1:0] d);
    for (int i = 0; i < CPB; i++) exp_q.push_back(1'b0);
    for (int b = 0; b < DW; b++)
      for (int i = 0; i < CPB; i++) exp_q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
    for (int i = 0; i < CPB; i++) exp_q.push_back(^d);
`endif
    for (int i = 0; i < CPB; i++) exp_q.push_back(1'b1);
  endtask

  // One clock: compare mid-cycle, then advance model after the edge.
  task automatic step();
    logic exp_pop;
    @(negedge clk);
    // The line is free to take a new word when idle or in its final cycle.
    exp_pop = !rst && tx_en && (fifo_q.size() > 0) && (exp_q.size() <= 1);
    check("tx",         {31'd0, tx},         {31'd0, (exp_q.size() > 0) ? exp_q[0] : 1'b1});
    check("busy",       {31'd0, busy},       {31'd0, exp_q.size() > 0});
    check("frame_done", {31'd0, frame_done}, {31'd0, exp_q.size() == 1});
    check("fifo_ren",   {31'd0, fifo_ren},   {31'd0, exp_pop});
    if (fifo_ren) dut_pops++;
    if (prev_tx && !tx) starts.push_back(cyc);
    prev_tx = tx;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (exp_pop) push_frame(fifo_q.pop_front());
    drive_fifo();
  endtask

  initial begin
    cyc     = 0;
    prev_tx = 1'b1;
    rst     = 1'b1;
    tx_en   = 1'b0;
    drive_fifo();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",   {31'd0, tx},         32'd1);
    check("rst_busy", {31'd0, busy},       32'd0);
    check("rst_fd",   {31'd0, frame_done}, 32'd0);
    check("rst_ren",  {31'd0, fifo_ren},   32'd0);
    rst   = 1'b0;
    tx_en = 1'b1;

    // Idle with empty FIFO.
    dut_pops = 0;
    repeat (50) step();
    check("idle_pops", dut_pops, 0);

    // Single byte.
    dut_pops = 0;
    fifo_q.push_back(8'hA5);
    drive_fifo();
    repeat (FRAME_LEN + 10) step();
    check("single_pops", dut_pops, 1);
    check("single_busy_end", {31'd0, busy}, 32'd0);

    // Back-to-back.
    dut_pops = 0;
    starts.delete();
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    drive_fifo();
    repeat (2 * FRAME_LEN + 10) step();
    check("b2b_pops", dut_pops, 2);
    check("b2b_starts", starts.size(), 2);
    if (starts.size() >= 2) check("b2b_spacing", starts[1] - starts[0], FRAME_LEN);

    // Gating: drop tx_en 10 cycles into 0x3C with 0x55 queued.
    dut_pops = 0;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'h55);
    drive_fifo();
    repeat (11) step();
    tx_en = 1'b0;
    repeat (FRAME_LEN + 20) step();
    check("gate_pops", dut_pops, 1);
    check("gate_idle_busy", {31'd0, busy}, 32'd0);
    tx_en = 1'b1;
    repeat (FRAME_LEN + 10) step();
    check("gate_resume_pops", dut_pops, 2);

    // Reset mid-frame, 15 cycles after the pop (inside a 0 data bit).
    dut_pops = 0;
    fifo_q.push_back(8'h81);
    drive_fifo();
    repeat (16) step();
    check("pre_rst_tx", {31'd0, tx}, {31'd0, exp_q[0]});
    rst = 1'b1;
    #1;
    check("async_rst_tx",   {31'd0, tx},   32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (2) step();
    rst = 1'b0;
    repeat (30) step();
    check("rst_no_reread", dut_pops, 1);

    // Randomised traffic with random tx_en gating.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0 && fifo_q.size() < 4) begin
        fifo_q.push_back(DW'($urandom));
        drive_fifo();
      end
      tx_en = ($urandom_range(0, 15) != 0);
      step();
    end
    tx_en = 1'b1;
    repeat (5 * FRAME_LEN) step();
    check("drain_empty", fifo_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
